product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Downstream stage of the 4-bit multiplier. It consumes 8-bit products, sums a fixed-length frame of them, and hands off the frame sum.

Interface
REQ-001 Parameter N_TERMS, default 4, number of products per frame; legal range 1..16.
REQ-002 Parameter ACC_W, default 12, accumulator/sum width; legal range 8..16.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 p_in  input  8  unsigned product from the multiplier (0..225).
REQ-006 p_valid  input  1  p_in holds a valid product.
REQ-007 p_ready  output  1  block can accept a product this cycle.
REQ-008 clear  input  1  synchronous frame abort.
REQ-009 sum_out  output  ACC_W  frame sum, meaningful only while sum_valid=1.
REQ-010 sum_valid  output  1  frame sum available.
REQ-011 sum_ready  input  1  consumer accepts the sum.
REQ-012 ovf  output  1  the frame saturated.
REQ-013 term_cnt  output  5  number of products accepted in the current frame.

Function
REQ-014 The block shall have three states: IDLE (no terms accepted), ACC (1..N_TERMS-1 terms accepted) and DONE (sum held for handoff).
REQ-015 An input transfer shall occur on a rising edge where p_valid=1 and p_ready=1; an output transfer shall occur on a rising edge where sum_valid=1 and sum_ready=1.
REQ-016 p_ready shall be 1 in IDLE and ACC and 0 in DONE; p_ready shall also be 0 whenever clear=1 or rst_n=0.
REQ-017 IDLE, on an input transfer: acc<=p_in, term_cnt<=1; next state DONE if N_TERMS==1, otherwise ACC.
REQ-018 ACC, on an input transfer: acc<=acc+p_in, term_cnt<=term_cnt+1; next state DONE when the new term_cnt equals N_TERMS, otherwise ACC.
REQ-019 IDLE/ACC without an input transfer: acc, term_cnt and state shall hold, including when p_valid=0.
REQ-020 Arithmetic shall be unsigned; the sum shall be formed at ACC_W+1 bits. If it exceeds 2^ACC_W-1, acc shall become 2^ACC_W-1 and ovf shall be set.
REQ-021 ovf shall be sticky for the frame, once set staying 1 even if later additions are 0.
REQ-022 sum_out shall be a registered copy of acc. sum_valid shall be 1 exactly in DONE, from the cycle after the edge that accepts the last term.
REQ-023 DONE: sum_out, ovf and term_cnt shall remain stable until the output transfer. With sum_ready=0 the block shall stall indefinitely.
REQ-024 DONE, on the output transfer: next state IDLE, acc<=0, term_cnt<=0, ovf<=0. A new product is first accepted in the following cycle, so no same-cycle bypass exists.
REQ-025 Throughput: one frame per N_TERMS+1 cycles at best (N_TERMS input cycles plus 1 DONE cycle with sum_ready=1).
REQ-026 clear=1 at a rising edge, in any state: next state IDLE, acc=0, term_cnt=0, ovf=0, sum_valid=0. clear shall take priority over both transfers; a product presented that cycle is not consumed and a pending sum is discarded.

Reset
REQ-027 While rst_n=0, regardless of clk: state=IDLE, acc=0, sum_out=0, term_cnt=0, ovf=0, sum_valid=0, p_ready=0.
REQ-028 After rst_n deasserts, p_ready shall be 1 combinationally (state IDLE). The first input transfer can occur at the first rising edge after deassertion.
REQ-029 Reset asserted mid-frame or in DONE shall discard all partial or held results immediately.

Verification
REQ-030 Default parameters; products 0,6,52,100 on consecutive cycles, sum_ready=1 -> sum_valid=1 the cycle after the 4th accept; sum_out=12'h09E (158), ovf=0, term_cnt=4; IDLE on the next edge.
REQ-031 Backpressure: complete a frame with sum_ready=0 for 3 cycles -> sum_valid, sum_out and p_ready=0 stable for all 3 cycles; an offered product is not consumed; the sum is accepted when sum_ready rises.
REQ-032 ACC_W=8, N_TERMS=2; products 200,100 -> sum_out=8'hFF, ovf=1; next frame 1,2 -> sum_out=3, ovf=0.
REQ-033 Two products (225,225) accepted, then clear=1 with p_valid=1, p_in=9 -> term_cnt=0, p_in not consumed; next frame 1,1,1,1 -> sum_out=4.
REQ-034 rst_n pulsed low between clock edges after 3 accepted terms -> all outputs 0 at once; a subsequent 4-term frame of 225s -> sum_out=900 (12'h384), ovf=0.
REQ-035 N_TERMS=1; product 225 -> sum_valid=1 the next cycle with sum_out=225; gaps in p_valid do not alter acc.

Source files
------------

// File: rtl/product_accumulator.sv
`timescale 1ns/1ps
// product_accumulator: sums a fixed-length frame of 8-bit unsigned products
// and hands the frame sum off over a valid/ready interface.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   p_in       unsigned product (0..225)
//   p_valid    p_in holds a valid product
//   p_ready    block can accept a product this cycle (combinational)
//   clear      synchronous frame abort, overrides both transfers
//   sum_out    frame sum, meaningful while sum_valid=1
//   sum_valid  frame sum available
//   sum_ready  consumer accepts the sum
//   ovf        the frame saturated (sticky for the frame)
//   term_cnt   products accepted in the current frame
module product_accumulator #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       p_in,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             ovf,
  output logic [4:0]       term_cnt
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned CNT_W = 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS);

  logic [1:0]       state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic [SUM_W-1:0] sum_w;
  logic             in_xfer;
  logic             out_xfer;

  // Input handshake: never ready while holding a sum, aborting or in reset.
  assign p_ready  = rst_n & ~clear & (state != DONE);
  assign in_xfer  = p_valid & p_ready;
  assign out_xfer = sum_valid & sum_ready;

  // One extra bit catches the carry that triggers saturation.
  assign sum_w = {1'b0, acc} + SUM_W'(p_in);

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = term_cnt;
    ovf_nxt   = ovf;

    if (clear) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_xfer) begin
            acc_nxt   = ACC_W'(p_in);
            cnt_nxt   = CNT_W'(1);
            state_nxt = (LAST_CNT == CNT_W'(1)) ? DONE : ACC;
          end
        end
        ACC: begin
          if (in_xfer) begin
            if (sum_w[ACC_W]) begin
              acc_nxt = ACC_MAX;
              ovf_nxt = 1'b1;
            end else begin
              acc_nxt = sum_w[ACC_W-1:0];
            end
            cnt_nxt   = term_cnt + CNT_W'(1);
            state_nxt = (cnt_nxt == LAST_CNT) ? DONE : ACC;
          end
        end
        DONE: begin
          if (out_xfer) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
          end
        end
        default: begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; sum_out tracks acc so it is valid on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      term_cnt  <= '0;
      ovf       <= 1'b0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      term_cnt  <= cnt_nxt;
      ovf       <= ovf_nxt;
      sum_out   <= acc_nxt;
      sum_valid <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
`timescale 1ns/1ps
// Bench for product_accumulator: three instances (4x12, 2x8, 1x12) checked
// every cycle against a frame-level model, plus literal frame expectations.
module tb_product_accumulator;

  logic clk;
  logic rst_n;
  logic [2:0]      p_valid, clear, sum_ready;
  logic [2:0][7:0] p_in;
  wire  [2:0]      p_ready, sum_valid, ovf;
  wire  [2:0][4:0] term_cnt;
  wire  [11:0]     sum0;
  wire  [7:0]      sum1;
  wire  [11:0]     sum2;

  int checks = 0;
  int errors = 0;

  localparam int NT [3] = '{4, 2, 1};
  localparam int AW [3] = '{12, 8, 12};

  product_accumulator #(.N_TERMS(4), .ACC_W(12)) u_d0 (
    .clk(clk), .rst_n(rst_n), .p_in(p_in[0]), .p_valid(p_valid[0]), .p_ready(p_ready[0]),
    .clear(clear[0]), .sum_out(sum0), .sum_valid(sum_valid[0]), .sum_ready(sum_ready[0]),
    .ovf(ovf[0]), .term_cnt(term_cnt[0]));
  product_accumulator #(.N_TERMS(2), .ACC_W(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .p_in(p_in[1]), .p_valid(p_valid[1]), .p_ready(p_ready[1]),
    .clear(clear[1]), .sum_out(sum1), .sum_valid(sum_valid[1]), .sum_ready(sum_ready[1]),
    .ovf(ovf[1]), .term_cnt(term_cnt[1]));
  product_accumulator #(.N_TERMS(1), .ACC_W(12)) u_d2 (
    .clk(clk), .rst_n(rst_n), .p_in(p_in[2]), .p_valid(p_valid[2]), .p_ready(p_ready[2]),
    .clear(clear[2]), .sum_out(sum2), .sum_valid(sum_valid[2]), .sum_ready(sum_ready[2]),
    .ovf(ovf[2]), .term_cnt(term_cnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame model: products accepted, their plain integer total, and whether
  // the frame is complete and waiting for handoff.
  typedef struct {
    int cnt;
    int total;
    bit done;
  } model_t;

  model_t m [3];

  function automatic model_t fresh();
    model_t r;
    r.cnt = 0;
    r.total = 0;
    r.done = 1'b0;
    return r;
  endfunction

  function automatic model_t step(model_t s, int n, bit pv, int pin, bit clr, bit sr);
    model_t r = s;
    if (clr) r = fresh();
    else if (s.done) begin
      if (sr) r = fresh();
    end else if (pv) begin
      r.total = s.total + pin;
      r.cnt = s.cnt + 1;
      r.done = (r.cnt == n);
    end
    return r;
  endfunction

  // Saturating addition of non-negative terms clamps exactly when the total does.
  function automatic int max_of(int i);
    return (1 << AW[i]) - 1;
  endfunction

  function automatic int exp_sum(int i);
    return (m[i].total > max_of(i)) ? max_of(i) : m[i].total;
  endfunction

  function automatic int act_sum(int i);
    case (i)
      0: return int'(sum0);
      1: return int'(sum1);
      default: return int'(sum2);
    endcase
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m[i] = fresh();
    end else begin
      for (int i = 0; i < 3; i++)
        m[i] = step(m[i], NT[i], p_valid[i], int'(p_in[i]), clear[i], sum_ready[i]);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d p_ready", i), int'(p_ready[i]),
          int'(rst_n && !clear[i] && !m[i].done));
      chk($sformatf("d%0d sum_valid", i), int'(sum_valid[i]), int'(m[i].done));
      chk($sformatf("d%0d term_cnt", i), int'(term_cnt[i]), m[i].cnt);
      chk($sformatf("d%0d ovf", i), int'(ovf[i]), int'(m[i].total > max_of(i)));
      if (m[i].done || !rst_n)
        chk($sformatf("d%0d sum_out", i), act_sum(i), exp_sum(i));
    end
  end

  task automatic put(int i, bit pv, int pin, bit clr, bit sr);
    p_valid[i]   = pv;
    p_in[i]      = 8'(pin);
    clear[i]     = clr;
    sum_ready[i] = sr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    p_valid = '0;
    clear = '0;
    sum_ready = '0;
    p_in = '0;
    #2;
    chk("reset p_ready", int'(p_ready[0]), 0);
    chk("reset sum_out", int'(sum0), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    chk("post-reset p_ready", int'(p_ready[0]), 1);

    // Basic frame 0,6,52,100.
    put(0, 1, 0, 0, 1);   tick();
    put(0, 1, 6, 0, 1);   tick();
    put(0, 1, 52, 0, 1);  tick();
    put(0, 1, 100, 0, 1); tick();
    chk("basic sum_valid", int'(sum_valid[0]), 1);
    chk("basic sum_out", int'(sum0), 158);
    chk("basic ovf", int'(ovf[0]), 0);
    chk("basic term_cnt", int'(term_cnt[0]), 4);
    put(0, 0, 0, 0, 1); tick();
    chk("basic idle sum_valid", int'(sum_valid[0]), 0);
    chk("basic idle term_cnt", int'(term_cnt[0]), 0);

    // Backpressure: sum held for three cycles, offered product ignored.
    put(0, 1, 10, 0, 0); tick();
    put(0, 1, 20, 0, 0); tick();
    put(0, 1, 30, 0, 0); tick();
    put(0, 1, 40, 0, 0); tick();
    for (int k = 0; k < 3; k++) begin
      put(0, 1, 77, 0, 0);
      #1;
      chk("stall p_ready", int'(p_ready[0]), 0);
      chk("stall sum_valid", int'(sum_valid[0]), 1);
      chk("stall sum_out", int'(sum0), 100);
      chk("stall term_cnt", int'(term_cnt[0]), 4);
      tick();
    end
    put(0, 0, 0, 0, 1); tick();
    chk("stall release sum_valid", int'(sum_valid[0]), 0);
    chk("stall release term_cnt", int'(term_cnt[0]), 0);

    // Clear mid-frame with a product offered.
    put(0, 1, 225, 0, 1); tick();
    put(0, 1, 225, 0, 1); tick();
    chk("pre-clear term_cnt", int'(term_cnt[0]), 2);
    put(0, 1, 9, 1, 1); tick();
    chk("clear term_cnt", int'(term_cnt[0]), 0);
    put(0, 1, 1, 0, 1);
    repeat (4) tick();
    chk("after clear sum_out", int'(sum0), 4);
    chk("after clear sum_valid", int'(sum_valid[0]), 1);
    put(0, 0, 0, 0, 1); tick();

    // Asynchronous reset between edges after three accepts.
    put(0, 1, 225, 0, 1);
    repeat (3) tick();
    put(0, 0, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset term_cnt", int'(term_cnt[0]), 0);
    chk("mid reset p_ready", int'(p_ready[0]), 0);
    chk("mid reset sum_valid", int'(sum_valid[0]), 0);
    chk("mid reset ovf", int'(ovf[0]), 0);
    chk("mid reset sum_out", int'(sum0), 0);
    #1 rst_n = 1'b1;
    put(0, 1, 225, 0, 1);
    repeat (4) tick();
    chk("900 sum_out", int'(sum0), 900);
    chk("900 ovf", int'(ovf[0]), 0);
    put(0, 0, 0, 0, 1); tick();

    // 8-bit accumulator saturation, then a clean frame.
    put(1, 1, 200, 0, 1); tick();
    put(1, 1, 100, 0, 1); tick();
    chk("sat sum_out", int'(sum1), 255);
    chk("sat ovf", int'(ovf[1]), 1);
    put(1, 0, 0, 0, 1); tick();
    chk("sat cleared ovf", int'(ovf[1]), 0);
    put(1, 1, 1, 0, 1); tick();
    put(1, 1, 2, 0, 1); tick();
    chk("post-sat sum_out", int'(sum1), 3);
    chk("post-sat ovf", int'(ovf[1]), 0);
    put(1, 0, 0, 0, 1); tick();

    // Single-term frames with gaps.
    put(2, 1, 225, 0, 1); tick();
    chk("n1 sum_valid", int'(sum_valid[2]), 1);
    chk("n1 sum_out", int'(sum2), 225);
    put(2, 0, 99, 0, 1);
    repeat (3) tick();
    chk("n1 gap sum_valid", int'(sum_valid[2]), 0);
    put(2, 1, 17, 0, 1); tick();
    chk("n1 second sum_out", int'(sum2), 17);
    put(2, 0, 0, 0, 1); tick();

    // Randomized traffic on all three instances.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        p_valid[i]   = ($urandom_range(3) != 0);
        p_in[i]      = ($urandom_range(7) == 0) ? 8'd225 : 8'($urandom_range(225));
        clear[i]     = ($urandom_range(40) == 0);
        sum_ready[i] = ($urandom_range(2) != 0);
      end
      if ($urandom_range(600) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
